// File: rtl/lt24_touch_pkg.sv
// Shared types and constants for the LT24 touch ADC scan controller.
package lt24_touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_SCAN,
    ST_DONE,
    ST_GAP
  } scan_state_e;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SETUP,
    FR_XFER,
    FR_NEXT
  } frame_state_e;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS   = 8;
  localparam int DATA_FIRST = 9;
  localparam int DATA_BITS  = 12;

endpackage

// File: rtl/lt24_touch_spi_frame.sv
// One AD7843 conversion frame: CS setup, 8-bit command, 16 read periods, CS release.
// done_o pulses in the last release cycle so a follow-on start costs no idle cycle.
module lt24_touch_spi_frame
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  input  logic        dout_i,
  output logic        done_o,
  output logic [11:0] data_o,
  output logic        cs_n_o,
  output logic        dclk_o,
  output logic        din_o
);

  localparam int CW = $clog2(CLK_DIV);

  frame_state_e   st_q, st_d;
  logic [CW-1:0]  div_q, div_d;
  logic [5:0]     half_q, half_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [11:0]    sh_q, sh_d;
  logic           cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
  logic [1:0]     dout_sync_q;
  logic           dout_s, div_end;
  logic [4:0]     period;

  assign dout_s  = dout_sync_q[1];
  assign div_end = (div_q == CW'(CLK_DIV - 1));
  assign period  = half_q[5:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= FR_IDLE;
      div_q       <= '0;
      half_q      <= '0;
      cmd_q       <= '0;
      sh_q        <= '0;
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      dout_sync_q <= '0;
    end else begin
      st_q        <= st_d;
      div_q       <= div_d;
      half_q      <= half_d;
      cmd_q       <= cmd_d;
      sh_q        <= sh_d;
      cs_n_q      <= cs_n_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      dout_sync_q <= {dout_sync_q[0], dout_i};
    end
  end

  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    half_d = half_q;
    cmd_d  = cmd_q;
    sh_d   = sh_q;
    cs_n_d = cs_n_q;
    dclk_d = dclk_q;
    din_d  = din_q;
    done_o = 1'b0;
    case (st_q)
      FR_IDLE: begin
        if (start_i) begin
          st_d   = FR_SETUP;
          div_d  = '0;
          cs_n_d = 1'b0;
          cmd_d  = cmd_i;
        end
      end
      FR_SETUP: begin
        div_d = div_q + CW'(1);
        if (div_end) begin
          st_d   = FR_XFER;
          div_d  = '0;
          half_d = '0;
          din_d  = cmd_q[7];
        end
      end
      FR_XFER: begin
        div_d = div_q + CW'(1);
        // Even half = DCLK low; MOSI moves one cycle after the falling edge.
        if (!half_q[0] && div_q == '0)
          din_d = (period < 5'(CMD_BITS)) ? cmd_q[~period[2:0]] : 1'b0;
        // Last cycle of the high half hides the 2-flop synchroniser delay.
        if (half_q[0] && div_end && period >= 5'(DATA_FIRST) &&
            period < 5'(DATA_FIRST + DATA_BITS))
          sh_d = {sh_q[10:0], dout_s};
        if (div_end) begin
          div_d  = '0;
          half_d = half_q + 6'd1;
          dclk_d = ~half_q[0];
          if (half_q == 6'(2 * FRAME_BITS - 1)) begin
            st_d   = FR_NEXT;
            cs_n_d = 1'b1;
            din_d  = 1'b0;
          end
        end
      end
      FR_NEXT: begin
        div_d = div_q + CW'(1);
        if (div_end) begin
          done_o = 1'b1;
          div_d  = '0;
          if (start_i) begin
            st_d   = FR_SETUP;
            cs_n_d = 1'b0;
            cmd_d  = cmd_i;
          end else begin
            st_d = FR_IDLE;
          end
        end
      end
      default: st_d = FR_IDLE;
    endcase
  end

  assign data_o = sh_q;
  assign cs_n_o = cs_n_q;
  assign dclk_o = dclk_q;
  assign din_o  = din_q;

endmodule

// File: rtl/lt24_touch_scanner.sv
// LT24 touch scan controller: pen debounce, X/Y conversion sequencing,
// per-axis averaging and inter-scan gap around the SPI frame engine.
module lt24_touch_scanner
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int AVG_LOG2 = 2,
  parameter int DEBOUNCE = 50000,
  parameter int SCAN_GAP = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pen_irq_n,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_dclk,
  output logic        adc_din,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        sample_valid,
  output logic        pen_down
);

  localparam int NCONV = 1 << AVG_LOG2;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNV_W = AVG_LOG2 + 2;

  scan_state_e      st_q, st_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [CNV_W-1:0] conv_q, conv_d, conv_nx;
  logic [ACC_W-1:0] accx_q, accx_d, accy_q, accy_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic             sv_q, sv_d, pd_q, pd_d;
  logic [1:0]       pen_sync_q;
  logic             pen_s, go;
  logic             fr_start, fr_done;
  logic [7:0]       fr_cmd;
  logic [11:0]      fr_data;

  assign pen_s   = pen_sync_q[1];
  assign conv_nx = conv_q + CNV_W'(1);

  lt24_touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk     (clk),
    .reset   (reset),
    .start_i (fr_start),
    .cmd_i   (fr_cmd),
    .dout_i  (adc_dout),
    .done_o  (fr_done),
    .data_o  (fr_data),
    .cs_n_o  (adc_cs_n),
    .dclk_o  (adc_dclk),
    .din_o   (adc_din)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      conv_q     <= '0;
      accx_q     <= '0;
      accy_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sv_q       <= 1'b0;
      pd_q       <= 1'b0;
      pen_sync_q <= 2'b11;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      conv_q     <= conv_d;
      accx_q     <= accx_d;
      accy_q     <= accy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sv_q       <= sv_d;
      pd_q       <= pd_d;
      pen_sync_q <= {pen_sync_q[0], pen_irq_n};
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    conv_d   = conv_q;
    accx_d   = accx_q;
    accy_d   = accy_q;
    x_d      = x_q;
    y_d      = y_q;
    sv_d     = 1'b0;
    pd_d     = pd_q;
    go       = 1'b0;
    fr_start = 1'b0;
    fr_cmd   = CMD_X;
    case (st_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable && !pen_s) st_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (pen_s) begin
          st_d = ST_IDLE;
        end else if (cnt_q == 32'(DEBOUNCE - 1)) begin
          pd_d = 1'b1;
          go   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SCAN: begin
        // Pen line is meaningless while CS is low, so it is not looked at here.
        if (fr_done) begin
          if (conv_q < CNV_W'(NCONV)) accx_d = accx_q + ACC_W'(fr_data);
          else                        accy_d = accy_q + ACC_W'(fr_data);
          conv_d = conv_nx;
          if (conv_q == CNV_W'(2 * NCONV - 1)) begin
            st_d = ST_DONE;
          end else begin
            fr_start = 1'b1;
            fr_cmd   = (conv_nx < CNV_W'(NCONV)) ? CMD_X : CMD_Y;
          end
        end
      end
      ST_DONE: begin
        x_d   = accx_q[ACC_W-1:AVG_LOG2];
        y_d   = accy_q[ACC_W-1:AVG_LOG2];
        sv_d  = 1'b1;
        cnt_d = '0;
        st_d  = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == 32'(SCAN_GAP - 1)) begin
          cnt_d = '0;
          if (!pen_s && enable) begin
            go = 1'b1;
          end else begin
            pd_d = 1'b0;
            st_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (go) begin
      st_d     = ST_SCAN;
      conv_d   = '0;
      accx_d   = '0;
      accy_d   = '0;
      fr_start = 1'b1;
      fr_cmd   = CMD_X;
    end
  end

  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign sample_valid = sv_q;
  assign pen_down     = pd_q;

endmodule

// File: tb/tb_lt24_touch_scanner.sv
// Scoreboard bench for lt24_touch_scanner with a behavioural AD7843 model.
module tb_lt24_touch_scanner;

  localparam int CD  = 4;
  localparam int AL  = 2;
  localparam int DEB = 200;
  localparam int GAP = 3000;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, pen_irq_n = 1'b1, adc_dout = 1'b0;
  logic        adc_cs_n, adc_dclk, adc_din, sample_valid, pen_down;
  logic [11:0] x_pos, y_pos;

  lt24_touch_scanner #(.CLK_DIV(CD), .AVG_LOG2(AL), .DEBOUNCE(DEB), .SCAN_GAP(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pen_irq_n    (pen_irq_n),
    .adc_dout     (adc_dout),
    .adc_cs_n     (adc_cs_n),
    .adc_dclk     (adc_dclk),
    .adc_din      (adc_din),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .sample_valid (sample_valid),
    .pen_down     (pen_down)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, cyc = 0, frames = 0, rises = 0, falls = 0;
  int          sv_cnt = 0, xi = 0, yi = 0;
  logic [7:0]  cmd_sh = '0;
  logic        rd_din = 1'b0;
  logic [11:0] cur = '0;
  logic [11:0] xv [4];
  logic [11:0] yv [4];
  logic [23:0] e;
  logic [23:0] exp_q [$];
  time         t_rise = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exv);
    end
  endtask

  task automatic set_vals(input logic [11:0] x0, x1, x2, x3, y0, y1, y2, y3);
    xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
    yv[0] = y0; yv[1] = y1; yv[2] = y2; yv[3] = y3;
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sample_valid && n < budget);
    chk(nm, sample_valid, 1);
  endtask

  task automatic wait_pd(input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!pen_down && n < budget);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: command clocked in on rising DCLK, result driven after falling DCLK
  always @(posedge adc_dclk) begin
    rises++;
    if (rises <= 8) cmd_sh = {cmd_sh[6:0], adc_din};
    else            rd_din = rd_din | adc_din;
  end

  always @(negedge adc_dclk) begin
    falls++;
    if (falls == 8) begin
      if (cmd_sh == 8'hD0) begin cur = xv[xi % 4]; xi++; end
      else                 begin cur = yv[yi % 4]; yi++; end
    end
    if (falls >= 9 && falls <= 20) adc_dout = cur[20 - falls];
    else                           adc_dout = 1'b0;
  end

  always @(negedge adc_cs_n) begin
    rises = 0; falls = 0; cmd_sh = '0; rd_din = 1'b0;
    if (frames % 8 != 0 && !reset) chk("cs_gap_cycles", 32'((($time - t_rise) / 10)), CD);
  end

  always @(posedge adc_cs_n) begin
    t_rise = $time;
    if (!reset) begin
      chk("dclk_rises", rises, 24);
      chk("din_cmd", {24'd0, cmd_sh}, (frames % 8 < 4) ? 32'hD0 : 32'h90);
      chk("din_read_zero", {31'd0, rd_din}, 0);
      frames++;
    end
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      sv_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("x_pos", {20'd0, x_pos}, {20'd0, e[23:12]});
        chk("y_pos", {20'd0, y_pos}, {20'd0, e[11:0]});
      end
    end
  end

  initial begin
    int n, c0, base;
    set_vals(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_dclk", adc_dclk, 0);
    chk("rst_din", adc_din, 0);
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_pen_down", pen_down, 0);
    reset = 1'b0; enable = 1'b1;

    // Three back-to-back scans with the pen held down
    set_vals(12'h123, 12'h123, 12'h123, 12'h123, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
    exp_q.push_back({12'h123, 12'hABC});
    pen_irq_n = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (adc_cs_n && n < 1000);
    c0 = cyc;
    wait_valid(2000, "valid_scan1");
    chk("scan_latency", cyc - c0, 8 * 50 * CD + 1);
    set_vals(12'd100, 12'd101, 12'd102, 12'd104, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    exp_q.push_back({12'd101, 12'hFFF});
    wait_valid(5000, "valid_scan2");
    set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'd0, 12'd1, 12'd2, 12'd3);
    exp_q.push_back({12'hFFF, 12'd1});
    wait_valid(5000, "valid_scan3");
    pen_irq_n = 1'b1;
    repeat (GAP + 50) @(negedge clk);
    chk("pd_after_release", pen_down, 0);
    chk("frames_three_scans", frames, 24);
    chk("valid_count_3", sv_cnt, 3);

    // Short press must not survive debounce
    base = frames;
    pen_irq_n = 1'b0;
    repeat (120) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("bounce_no_frames", frames, base);
    chk("bounce_pd_low", pen_down, 0);

    // Full debounce, then lift during the third X frame
    set_vals(12'h123, 12'h123, 12'h123, 12'h123, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
    exp_q.push_back({12'h123, 12'hABC});
    pen_irq_n = 1'b0;
    wait_pd(DEB + 50, n);
    chk("deb_len_ok", (n >= DEB && n <= DEB + 6), 1);
    chk("cs_low_with_pd", adc_cs_n, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(frames == base + 2 && !adc_cs_n) && n < 2000);
    pen_irq_n = 1'b1;
    wait_valid(2000, "valid_lift");
    repeat (GAP + 50) @(negedge clk);
    chk("lift_pd_low", pen_down, 0);
    chk("lift_frames", frames, base + 8);

    // enable drops mid-scan: scan still published, then idle
    base = frames;
    exp_q.push_back({12'h123, 12'hABC});
    pen_irq_n = 1'b0;
    wait_pd(DEB + 50, n);
    chk("en_pd_high", pen_down, 1);
    enable = 1'b0;
    wait_valid(2000, "valid_en_drop");
    repeat (GAP + 50) @(negedge clk);
    chk("en_pd_low", pen_down, 0);
    chk("en_frames", frames, base + 8);
    pen_irq_n = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;

    // Reset in the middle of a transfer
    pen_irq_n = 1'b0;
    wait_pd(DEB + 50, n);
    n = 0;
    do begin @(negedge clk); n++; end while (rises < 3 && n < 500);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_n", adc_cs_n, 1);
    chk("mid_rst_dclk", adc_dclk, 0);
    chk("mid_rst_x", x_pos, 0);
    chk("mid_rst_y", y_pos, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_pd", pen_down, 0);
    xi = 0; yi = 0; frames = 0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({12'h123, 12'hABC});
    n = 0;
    do begin @(negedge clk); n++; end while (adc_cs_n && n < DEB + 50);
    chk("redebounce_after_rst", (n >= DEB && !adc_cs_n), 1);
    wait_valid(2000, "valid_after_rst");
    pen_irq_n = 1'b1;
    repeat (GAP + 50) @(negedge clk);
    chk("rst_scan_frames", frames, 8);
    chk("sb_empty", exp_q.size(), 0);
    chk("valid_count_total", sv_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
